// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide engine.
// Holds the operation encodings, the FSM state type and small op-decode helpers.
package mips_defs;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } md_state_e;

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the E stage and the multiply/divide engine.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  stall_req, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output stall_req, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_unit_core.sv
// Iterative datapath: one shift-add multiply step or one restoring divide step per cycle.
// acc holds {partial, multiplier/quotient}; the extra top bit absorbs the add carry.
module muldiv_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               init_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   acc_init_i,
  input  logic [WIDTH-1:0]   opnd_init_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0]   opnd_o,
  output logic               last_o
);

  logic [2*WIDTH:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum, rem_sh, rem_sub;
  logic             ge;

  always_comb begin
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    sum     = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge      = rem_sh >= {1'b0, opnd_q};
    rem_sub = rem_sh - {1'b0, opnd_q};
    if (init_i) begin
      acc_d  = {{(WIDTH + 1){1'b0}}, acc_init_i};
      opnd_d = opnd_init_i;
      cnt_d  = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_i) begin
        // Remainder shifts in the next dividend bit; quotient bit enters at the bottom.
        acc_d = {(ge ? rem_sub : rem_sh), acc_q[WIDTH-2:0], ge};
      end else begin
        acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc_o  = acc_q[2*WIDTH-1:0];
  assign opnd_o = opnd_q;
  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide engine: FSM, sign handling, HI/LO registers and pipeline stall.
// Works on operand magnitudes and fixes the signs up in FIX.
module muldiv_unit
  import mips_defs::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_ITER = 1,
  parameter int unsigned CNT_W    = $clog2(WIDTH + 1)
) (
  input logic          clka,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  md_state_e state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               div_zero_q, div_zero_d;
  logic               accept, core_step, core_last;
  logic [WIDTH-1:0]   a_mag, b_mag, core_opnd, quot, rem;
  logic [2*WIDTH-1:0] core_acc, prod_mag;

  assign accept    = (state_q == StIdle) & bus.start & ~bus.cancel;
  assign core_step = (state_q == StRun) & ~bus.cancel;
  assign a_mag = (md_is_signed(bus.op) & bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign b_mag = (md_is_signed(bus.op) & bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

  // Multiply keeps the multiplier in acc and the multiplicand as opnd; divide the reverse.
  muldiv_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i       (clka),
    .rst_ni      (rst),
    .init_i      (accept),
    .step_i      (core_step),
    .div_i       (md_is_div(op_q)),
    .acc_init_i  (md_is_div(bus.op) ? a_mag : b_mag),
    .opnd_init_i (md_is_div(bus.op) ? b_mag : a_mag),
    .acc_o       (core_acc),
    .opnd_o      (core_opnd),
    .last_o      (core_last)
  );

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.cancel) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (md_is_div(bus.op) ? (bus.src_b == '0) : (MUL_ITER == 0)) state_d = StFix;
            else state_d = StRun;
          end
        end
        StRun:   if (core_last) state_d = StFix;
        StFix:   state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.stall_req = accept | (state_q == StRun) | (state_q == StFix);
    bus.done      = (state_q == StDone) & ~bus.cancel;
    op_d = op_q;
    sa_d = sa_q;
    sb_d = sb_q;
    dz_d = dz_q;
    if (accept) begin
      op_d = bus.op;
      sa_d = md_is_signed(bus.op) & bus.src_a[WIDTH-1];
      sb_d = md_is_signed(bus.op) & bus.src_b[WIDTH-1];
      dz_d = md_is_div(bus.op) & (bus.src_b == '0);
    end
    if (MUL_ITER == 0) begin
      prod_mag = {{WIDTH{1'b0}}, core_opnd} * {{WIDTH{1'b0}}, core_acc[WIDTH-1:0]};
    end else begin
      prod_mag = core_acc;
    end
    quot       = core_acc[WIDTH-1:0];
    rem        = core_acc[2*WIDTH-1:WIDTH];
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    if ((state_q == StFix) && !bus.cancel) begin
      div_zero_d = dz_q;
      if (!md_is_div(op_q)) begin
        {hi_d, lo_d} = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
      end else if (dz_q) begin
        // acc still holds |src_a|; re-apply its sign to return the raw dividend bits.
        lo_d = '1;
        hi_d = sa_q ? -quot : quot;
      end else begin
        lo_d = (sa_q ^ sb_q) ? -quot : quot;
        hi_d = sa_q ? -rem : rem;
      end
    end
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      op_q       <= MD_MULT;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed and random ops on an iterative and a single-cycle-multiply
// instance, checked against an arithmetic reference model.
module tb_muldiv_unit;
  import mips_defs::*;

  logic        clka, rst, sel, start_r, cancel_r;
  logic [1:0]  op_r;
  logic [31:0] a_r, b_r;
  logic        m_done, m_stall, m_dz;
  logic [31:0] m_hi, m_lo;
  logic [64:0] last_exp;
  int          n_pass, n_total;

  muldiv_unit_if #(.WIDTH(32)) bus_it ();
  muldiv_unit_if #(.WIDTH(32)) bus_fc ();

  muldiv_unit #(.WIDTH(32), .MUL_ITER(1)) u_dut_it (.clka(clka), .rst(rst), .bus(bus_it));
  muldiv_unit #(.WIDTH(32), .MUL_ITER(0)) u_dut_fc (.clka(clka), .rst(rst), .bus(bus_fc));

  // sel=0 drives/observes the iterative instance, sel=1 the single-cycle-multiply one.
  assign bus_it.start  = start_r & ~sel;
  assign bus_fc.start  = start_r & sel;
  assign bus_it.op     = op_r;
  assign bus_fc.op     = op_r;
  assign bus_it.src_a  = a_r;
  assign bus_fc.src_a  = a_r;
  assign bus_it.src_b  = b_r;
  assign bus_fc.src_b  = b_r;
  assign bus_it.cancel = cancel_r & ~sel;
  assign bus_fc.cancel = cancel_r & sel;
  assign m_done  = sel ? bus_fc.done : bus_it.done;
  assign m_stall = sel ? bus_fc.stall_req : bus_it.stall_req;
  assign m_dz    = sel ? bus_fc.div_zero : bus_it.div_zero;
  assign m_hi    = sel ? bus_fc.hi : bus_it.hi;
  assign m_lo    = sel ? bus_fc.lo : bus_it.lo;

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Returns {div_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MD_MULT: begin
        p = sa * sb;
        return {1'b0, p};
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == MD_DIV) begin
          q = sa / sb;
          r = sa % sb;
          return {1'b0, r[31:0], q[31:0]};
        end
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_op(input logic s, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit repulse, input string tag);
    logic [64:0] exp;
    int exp_lat, e;
    bit got, stall_ok;
    exp = ref_md(op, a, b);
    exp_lat = ((op[1] && b == 32'd0) || (!op[1] && s)) ? 1 : 33;
    @(negedge clka);
    sel = s; start_r = 1'b1; op_r = op; a_r = a; b_r = b; cancel_r = 1'b0;
    #1 check({tag, "_stall_start"}, 64'(m_stall), 64'd1);
    @(posedge clka);
    e = 0; got = 0; stall_ok = 1;
    while (!got && e < 100) begin
      @(negedge clka);
      start_r = 1'b0;
      if (repulse && e == 5) begin
        start_r = 1'b1; op_r = MD_MULTU; a_r = 32'h1234; b_r = 32'h1;
      end
      if (m_done) got = 1;
      else begin
        if (!m_stall) stall_ok = 0;
        e++;
      end
    end
    check({tag, "_latency"}, 64'(e), 64'(exp_lat));
    check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    check({tag, "_stall_done"}, 64'(m_stall), 64'd0);
    check({tag, "_hi"}, 64'(m_hi), 64'(exp[63:32]));
    check({tag, "_lo"}, 64'(m_lo), 64'(exp[31:0]));
    check({tag, "_div_zero"}, 64'(m_dz), 64'(exp[64]));
    last_exp = exp;
    @(negedge clka);
    check({tag, "_done_pulse"}, 64'(m_done), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit saw_done, saw_stall;
    n_pass = 0; n_total = 0;
    sel = 0; start_r = 0; cancel_r = 0; op_r = MD_MULT; a_r = 0; b_r = 0; rst = 0;
    #12;
    check("rst_hi", 64'(m_hi), 64'd0);
    check("rst_lo", 64'(m_lo), 64'd0);
    check("rst_done", 64'(m_done), 64'd0);
    check("rst_dz", 64'(m_dz), 64'd0);
    check("rst_stall", 64'(m_stall), 64'd0);
    @(negedge clka);
    rst = 1;

    do_op(0, MD_MULT, 32'hFFFF_FFFF, 32'h2, 0, "mult_neg");
    do_op(0, MD_DIV, 32'hFFFF_FFF9, 32'h2, 0, "div_neg");
    do_op(0, MD_DIVU, 32'hFFFF_FFF9, 32'h2, 0, "divu");
    do_op(0, MD_DIVU, 32'h1234_5678, 32'h0, 0, "divu_zero");
    do_op(0, MD_MULTU, 32'd3, 32'd5, 0, "multu_clr_dz");

    // Cancel mid-RUN, then a start masked by cancel; nothing may complete.
    @(negedge clka);
    sel = 0; start_r = 1; op_r = MD_MULTU; a_r = 32'h10; b_r = 32'h10;
    @(posedge clka);
    @(negedge clka);
    start_r = 0;
    repeat (10) @(posedge clka);
    @(negedge clka);
    cancel_r = 1;
    saw_done = m_done;
    @(negedge clka);
    start_r = 1;
    #1 check("cancel_start_masked", 64'(m_stall), 64'd0);
    saw_done |= m_done;
    @(negedge clka);
    start_r = 0; cancel_r = 0;
    saw_stall = 0;
    repeat (40) begin
      @(negedge clka);
      saw_done |= m_done;
      saw_stall |= m_stall;
    end
    check("cancel_no_done", 64'(saw_done), 64'd0);
    check("cancel_idle", 64'(saw_stall), 64'd0);
    check("cancel_hi", 64'(m_hi), 64'(last_exp[63:32]));
    check("cancel_lo", 64'(m_lo), 64'(last_exp[31:0]));
    check("cancel_dz", 64'(m_dz), 64'(last_exp[64]));

    do_op(0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_ovf_restart");

    for (int i = 0; i < 12; i++) do_op(1, 2'($urandom_range(0, 3)), pick(), pick(), 0, "rnd_fc");
    do_op(1, MD_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, "fc_mult_max");
    for (int i = 0; i < 24; i++) do_op(0, 2'($urandom_range(0, 3)), pick(), pick(), 0, "rnd_it");

    // Asynchronous reset between clock edges while the iterative unit is in RUN.
    @(negedge clka);
    sel = 0; start_r = 1; op_r = MD_DIVU; a_r = $urandom; b_r = 32'd7;
    @(negedge clka);
    start_r = 0;
    repeat (8) @(negedge clka);
    #2 rst = 0;
    #1;
    check("arst_hi", 64'(m_hi), 64'd0);
    check("arst_lo", 64'(m_lo), 64'd0);
    check("arst_dz", 64'(m_dz), 64'd0);
    check("arst_done", 64'(m_done), 64'd0);
    check("arst_stall", 64'(m_stall), 64'd0);
    sel = 1;
    #1;
    check("arst_fc_hi", 64'(m_hi), 64'd0);
    check("arst_fc_lo", 64'(m_lo), 64'd0);
    @(negedge clka);
    rst = 1;
    do_op(0, MD_MULTU, 32'hDEAD_BEEF, 32'h0000_1001, 0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine for the HI/LO path of the 5-stage MIPS core.
- Executes MULT, MULTU, DIV and DIVU over several cycles and holds the pipeline through the stall network while it runs.
- Writes the 2×WIDTH result into internal HI/LO registers.
- Supports cancellation by pipeline flush.
- Optional single-cycle multiply mode.

Parameters:
- WIDTH, 32: operand width; HI and LO are WIDTH bits each.
- MUL_ITER, 1: 1 = shift-add multiply, one bit per cycle; 0 = single-cycle combinational multiply.
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived; do not override).

Ports:
- clka  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  E-stage request; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  WIDTH  rs operand (multiplicand / dividend).
- src_b  in  WIDTH  rt operand (multiplier / divisor).
- cancel  in  1  flush; aborts any operation in progress.
- stall_req  out  1  to hazard unit; holds PC, F, D and E.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div_zero  out  1  sticky flag: the last completed op was a divide by zero.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, hi=0, lo=0, done=0, div_zero=0, counter=0.
- States: IDLE, RUN, FIX, DONE.
- Start, edge E0:
  - A start sampled in IDLE with cancel=0 latches op, sign flags and operand magnitudes (|x| for signed ops, raw for unsigned ops).
  - Clears the partial product / partial remainder.
  - IDLE→RUN (MUL_ITER=0 multiply: IDLE→FIX; divisor==0 on DIV/DIVU: IDLE→FIX).
- RUN:
  - Edges E1..EWIDTH each perform one iteration. Multiply is shift-add on magnitudes. Divide is radix-2 restoring: shift the remainder left and subtract the divisor if the result is non-negative.
  - The counter increments each edge; at count==WIDTH-1, RUN→FIX.
- FIX:
  - Apply sign correction. Signed multiply: negate the 2W product if sa^sb. Signed divide: quotient sign is sa^sb; remainder takes the dividend sign.
  - Write hi/lo. Multiply: {hi,lo} = product. Divide: lo = quotient, hi = remainder.
  - FIX→DONE.
- DONE: done=1 for exactly this cycle, then DONE→IDLE. hi/lo are valid from this cycle onward and hold until the next FIX.
- Latency in start-edge counts: iterative op → done in the cycle after E(WIDTH+1), i.e. 33 edges at WIDTH=32. Single-cycle multiply or divide-by-zero → done in the cycle after E1.
- stall_req (combinational) = (state==IDLE & start & ~cancel) | state==RUN | state==FIX.
  - It is low in DONE, so E advances together with the result.
- Divide by zero: lo = all ones, hi = src_a as given (unsigned bits), div_zero=1.
- Any other completed op clears div_zero in FIX.
- Signed overflow (MIN / -1): lo = MIN, hi = 0. This falls out of WIDTH-bit unsigned magnitudes; no special case is needed.
- cancel=1 in any state:
  - Next state is IDLE; done is not asserted.
  - hi, lo and div_zero are unchanged.
  - cancel beats start in the same cycle.
- start while not IDLE is ignored; operands are not re-sampled.
- Arithmetic is unsigned on the (WIDTH+1)-bit remainder path and 2×WIDTH on the product path. No X-propagation: unused datapath registers are reset to 0.

Decomposition:
- Shared package mips_defs: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the state enum.
- One natural sub-module, muldiv_core: the RUN-state datapath (shift-add / restoring step, counter).
- The parent keeps the FSM, sign handling, HI/LO registers and stall_req.

Test Plan:
1. MULT, src_a=0xFFFFFFFF, src_b=0x00000002, start at E0 → stall_req high in the start cycle through FIX; done in the cycle after E33; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
2. DIV, src_a=0xFFFFFFF9 (-7), src_b=0x00000002 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0. The same operands with DIVU → lo=0x7FFFFFFC, hi=0x00000001.
3. DIVU, src_a=0x12345678, src_b=0 → done in the cycle after E1; lo=0xFFFFFFFF, hi=0x12345678, div_zero=1. A following MULTU 3×5 → lo=15, hi=0, div_zero=0.
4. MULTU 0x10×0x10 started, then cancel asserted at E10 → IDLE at E11, no done pulse, hi/lo keep their prior values. start re-asserted while cancel=1 is ignored.
5. DIV, src_a=0x80000000, src_b=0xFFFFFFFF → lo=0x80000000, hi=0; start pulsed again during RUN has no effect.
6. MUL_ITER=0 build: MULT 0x7FFFFFFF×0x7FFFFFFF → done in the cycle after E1; hi=0x3FFFFFFF, lo=0x00000001. Also assert rst low mid-RUN → asynchronous return to IDLE, all outputs 0.
